// File: rtl/fetch_stage_pkg.sv
// ---------------------------------------------------------------------------
// fetch_stage_pkg
// Shared constants for the fetch stage and the instruction RAM:
//   WORD      datapath / instruction width in bits
//   BYTE      bits per byte
//   INS_SIZE  bytes per instruction (PC increment)
//   HALT_WORD encoding that stops fetching when halt detection is built in
//   RESET_PC  default program counter after reset
// ---------------------------------------------------------------------------
package fetch_stage_pkg;

  localparam int          WORD      = 32;
  localparam int          BYTE      = 8;
  localparam int          INS_SIZE  = WORD / BYTE;
  localparam logic [31:0] HALT_WORD = 32'hFFFF_FFFF;
  localparam logic [31:0] RESET_PC  = 32'h0000_0000;

endpackage

// File: rtl/fetch_stage_queue.sv
// ---------------------------------------------------------------------------
// fetch_queue
// Small FIFO buffering fetched {instruction, pc} pairs between the RAM read
// port and decode. Storage is registered; the head entry is presented
// directly from the storage registers.
// Ports:
//   clk, rst    clock and synchronous active-high reset
//   i_flush     empty the queue (pointers and count to zero)
//   i_push      enqueue {i_instr, i_pc}
//   i_pop       drop the head entry
//   o_count     number of valid entries
//   o_instr     head instruction
//   o_pc        head instruction address
// ---------------------------------------------------------------------------
module fetch_queue #(
  parameter int W     = 32,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_flush,
  input  logic                       i_push,
  input  logic                       i_pop,
  input  logic [W-1:0]               i_instr,
  input  logic [W-1:0]               i_pc,
  output logic [$clog2(DEPTH):0]     o_count,
  output logic [W-1:0]               o_instr,
  output logic [W-1:0]               o_pc
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  r_instr [DEPTH];
  logic [W-1:0]  r_pc    [DEPTH];
  logic [AW-1:0] r_head;
  logic [AW-1:0] r_tail;
  logic [CW-1:0] r_count;

  // Pointers wrap naturally because DEPTH is a power of two. Storage is
  // cleared only by rst so the head reads as zero straight out of reset;
  // a flush just rewinds the pointers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_instr[i] <= '0;
        r_pc[i]    <= '0;
      end
    end else if (i_flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (i_push) begin
        r_instr[r_tail] <= i_instr;
        r_pc[r_tail]    <= i_pc;
        r_tail          <= r_tail + AW'(1);
      end
      if (i_pop) begin
        r_head <= r_head + AW'(1);
      end
      if (i_push && !i_pop) begin
        r_count <= r_count + CW'(1);
      end else if (i_pop && !i_push) begin
        r_count <= r_count - CW'(1);
      end
    end
  end

  assign o_count = r_count;
  assign o_instr = r_instr[r_head];
  assign o_pc    = r_pc[r_head];

endmodule

// File: rtl/fetch_stage.sv
// ---------------------------------------------------------------------------
// fetch_stage
// Instruction fetch: owns the program counter, drives the combinational
// instruction RAM read port, buffers fetched words in fetch_queue and hands
// them to decode over a valid/ready handshake. A redirect flushes the queue
// and restarts fetching at redirect_pc.
// Optional feature macro: FETCH_HALT_DETECT_EN -- when defined, fetching
// stops after a HALT_WORD is enqueued until the next redirect or reset.
// Ports:
//   clk, rst      clock and synchronous active-high reset
//   imem_addr     byte address to instruction RAM (equals pc)
//   imem_data     instruction RAM read data, same cycle
//   id_valid      head of queue holds an instruction
//   id_ready      decode takes the head this cycle
//   id_instr      head instruction
//   id_pc         head instruction address
//   id_pc_plus4   id_pc + 4
//   redirect      flush and restart at redirect_pc
//   redirect_pc   new fetch address, used unaligned as given
//   halted        fetch stopped on HALT_WORD
// ---------------------------------------------------------------------------
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter int              WORD      = fetch_stage_pkg::WORD,
  parameter logic [WORD-1:0] RESET_PC  = WORD'(fetch_stage_pkg::RESET_PC),
  parameter int              QDEPTH    = 2,
  parameter logic [WORD-1:0] HALT_WORD = WORD'(fetch_stage_pkg::HALT_WORD)
) (
  input  logic            clk,
  input  logic            rst,
  output logic [WORD-1:0] imem_addr,
  input  logic [WORD-1:0] imem_data,
  output logic            id_valid,
  input  logic            id_ready,
  output logic [WORD-1:0] id_instr,
  output logic [WORD-1:0] id_pc,
  output logic [WORD-1:0] id_pc_plus4,
  input  logic            redirect,
  input  logic [WORD-1:0] redirect_pc,
  output logic            halted
);

  localparam int CW = $clog2(QDEPTH) + 1;

`ifdef FETCH_HALT_DETECT_EN
  localparam bit HALT_EN = 1'b1;
`else
  localparam bit HALT_EN = 1'b0;
`endif

  logic [WORD-1:0] r_pc;
  logic            r_halted;
  logic [CW-1:0]   w_count;
  logic            w_pop;
  logic            w_push;

  // Redirect wins over everything except rst, so it masks both the pop and
  // the push. A full queue can still take a push when its head leaves.
  assign w_pop  = id_valid && id_ready && !redirect;
  assign w_push = !redirect && !r_halted && ((w_count < CW'(QDEPTH)) || w_pop);

  // PC advances only when the word at the current PC is actually enqueued.
  // Without halt detection HALT_EN is zero and the flag never sets.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc     <= RESET_PC;
      r_halted <= 1'b0;
    end else if (redirect) begin
      r_pc     <= redirect_pc;
      r_halted <= 1'b0;
    end else if (w_push) begin
      r_pc <= r_pc + WORD'(INS_SIZE);
      if (HALT_EN && (imem_data == HALT_WORD)) begin
        r_halted <= 1'b1;
      end
    end
  end

  fetch_queue #(
    .W     (WORD),
    .DEPTH (QDEPTH)
  ) u_queue (
    .clk     (clk),
    .rst     (rst),
    .i_flush (redirect),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_instr (imem_data),
    .i_pc    (r_pc),
    .o_count (w_count),
    .o_instr (id_instr),
    .o_pc    (id_pc)
  );

  assign imem_addr   = r_pc;
  assign id_valid    = (w_count != '0);
  assign id_pc_plus4 = id_pc + WORD'(INS_SIZE);
  assign halted      = r_halted;

endmodule
